// File: rtl/aib_axi_follower_resp_credit_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : aib_axi_follower_resp_credit_buf_if
// Description : Bundles the AXI B/R channels, link transmit channels, credit
//               return pulses and status outputs of the follower response
//               credit buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface aib_axi_follower_resp_credit_buf_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int B_DEPTH    = 8,
    parameter int R_DEPTH    = 16,
    parameter int CREDIT_W   = 8
);
    // Credit initial values, loaded every cycle reset is held
    logic [CREDIT_W-1:0]               init_b_credit;
    logic [CREDIT_W-1:0]               init_r_credit;

    // AXI write response channel from the user subordinate
    logic [ID_WIDTH-1:0]               m_axi_bid;
    logic [1:0]                        m_axi_bresp;
    logic                              m_axi_bvalid;
    logic                              m_axi_bready;

    // AXI read data channel from the user subordinate
    logic [ID_WIDTH-1:0]               m_axi_rid;
    logic [DATA_WIDTH-1:0]             m_axi_rdata;
    logic [1:0]                        m_axi_rresp;
    logic                              m_axi_rlast;
    logic                              m_axi_rvalid;
    logic                              m_axi_rready;

    // Link transmit path toward the leader
    logic [ID_WIDTH+1:0]               b_tx_data;
    logic                              b_tx_valid;
    logic                              b_tx_ready;
    logic [ID_WIDTH+DATA_WIDTH+2:0]    r_tx_data;
    logic                              r_tx_valid;
    logic                              r_tx_ready;

    // Credit returns from the leader
    logic                              b_credit_ret;
    logic                              r_credit_ret;

    // Status
    logic [CREDIT_W-1:0]               b_credit_cnt;
    logic [CREDIT_W-1:0]               r_credit_cnt;
    logic [$clog2(B_DEPTH+1)-1:0]      b_level;
    logic [$clog2(R_DEPTH+1)-1:0]      r_level;
    logic                              err_credit_ovf;

    // Environment side: AXI subordinate, link transmitter and credit source
    modport master (
        output init_b_credit, init_r_credit,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  b_tx_data, b_tx_valid,
        output b_tx_ready,
        input  r_tx_data, r_tx_valid,
        output r_tx_ready,
        output b_credit_ret, r_credit_ret,
        input  b_credit_cnt, r_credit_cnt, b_level, r_level, err_credit_ovf
    );

    // Buffer side
    modport slave (
        input  init_b_credit, init_r_credit,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output b_tx_data, b_tx_valid,
        input  b_tx_ready,
        output r_tx_data, r_tx_valid,
        input  r_tx_ready,
        input  b_credit_ret, r_credit_ret,
        output b_credit_cnt, r_credit_cnt, b_level, r_level, err_credit_ovf
    );
endinterface
`default_nettype wire

// File: rtl/aib_axi_follower_resp_credit_buf.sv
`default_nettype none
// ============================================================================
// Module      : aib_axi_follower_resp_credit_buf
// Description : Follower-side response return stage. Buffers AXI write
//               responses and read beats in two independent first-word
//               fall-through FIFOs and forwards each toward the AIB link only
//               while leader-granted credits are available.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_axi_follower_resp_credit_buf #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int B_DEPTH    = 8,
    parameter int R_DEPTH    = 16,
    parameter int CREDIT_W   = 8,
    parameter int CREDIT_EN  = 1
) (
    input  logic                                  clk_wr,
    input  logic                                  rst_wr,
    aib_axi_follower_resp_credit_buf_if.slave     bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_b_aw = $clog2(B_DEPTH);
    localparam int c_r_aw = $clog2(R_DEPTH);
    localparam int c_b_lw = $clog2(B_DEPTH + 1);
    localparam int c_r_lw = $clog2(R_DEPTH + 1);
    localparam int c_b_tw = ID_WIDTH + 2;
    localparam int c_r_tw = ID_WIDTH + DATA_WIDTH + 3;

    localparam logic [c_b_lw-1:0]   c_b_full    = c_b_lw'(B_DEPTH);
    localparam logic [c_r_lw-1:0]   c_r_full    = c_r_lw'(R_DEPTH);
    localparam logic [CREDIT_W-1:0] c_cnt_max   = {CREDIT_W{1'b1}};
    localparam logic                c_credit_on = (CREDIT_EN != 0);

    // ------------------------------------------------------------------------
    // B channel state
    // ------------------------------------------------------------------------
    logic [c_b_tw-1:0]   r_b_mem [B_DEPTH];
    logic [c_b_aw:0]     r_b_wptr;
    logic [c_b_aw:0]     r_b_rptr;
    logic [c_b_lw-1:0]   r_b_level;
    logic [CREDIT_W-1:0] r_b_cnt;
    logic                w_b_ready;
    logic                w_b_valid;
    logic                w_b_has_credit;
    logic                w_b_push;
    logic                w_b_pop;

    // ------------------------------------------------------------------------
    // R channel state
    // ------------------------------------------------------------------------
    logic [c_r_tw-1:0]   r_r_mem [R_DEPTH];
    logic [c_r_aw:0]     r_r_wptr;
    logic [c_r_aw:0]     r_r_rptr;
    logic [c_r_lw-1:0]   r_r_level;
    logic [CREDIT_W-1:0] r_r_cnt;
    logic                w_r_ready;
    logic                w_r_valid;
    logic                w_r_has_credit;
    logic                w_r_push;
    logic                w_r_pop;

    logic                r_err_ovf;
    logic                w_b_ovf;
    logic                w_r_ovf;

    // ------------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------------
    // AXI side accepts whenever a slot is free; reset forces ready low so
    // nothing is captured while the buffer is being cleared.
    assign w_b_ready      = !rst_wr && (r_b_level != c_b_full);
    assign w_r_ready      = !rst_wr && (r_r_level != c_r_full);

    // With credits disabled the counter value is irrelevant to forwarding.
    assign w_b_has_credit = !c_credit_on || (r_b_cnt != '0);
    assign w_r_has_credit = !c_credit_on || (r_r_cnt != '0);

    // A pop consumes a credit, so valid can only drop through a pop: the
    // offer stays up until the link takes it.
    assign w_b_valid      = !rst_wr && (r_b_level != '0) && w_b_has_credit;
    assign w_r_valid      = !rst_wr && (r_r_level != '0) && w_r_has_credit;

    assign w_b_push       = bus.m_axi_bvalid && w_b_ready;
    assign w_r_push       = bus.m_axi_rvalid && w_r_ready;
    assign w_b_pop        = w_b_valid && bus.b_tx_ready;
    assign w_r_pop        = w_r_valid && bus.r_tx_ready;

    // Credit return at the ceiling with no offsetting pop cannot be absorbed.
    assign w_b_ovf        = c_credit_on && bus.b_credit_ret && !w_b_pop && (r_b_cnt == c_cnt_max);
    assign w_r_ovf        = c_credit_on && bus.r_credit_ret && !w_r_pop && (r_r_cnt == c_cnt_max);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.m_axi_bready   = w_b_ready;
    assign bus.m_axi_rready   = w_r_ready;
    assign bus.b_tx_valid     = w_b_valid;
    assign bus.r_tx_valid     = w_r_valid;
    assign bus.b_tx_data      = r_b_mem[r_b_rptr[c_b_aw-1:0]];
    assign bus.r_tx_data      = r_r_mem[r_r_rptr[c_r_aw-1:0]];
    assign bus.b_level        = r_b_level;
    assign bus.r_level        = r_r_level;
    assign bus.b_credit_cnt   = r_b_cnt;
    assign bus.r_credit_cnt   = r_r_cnt;
    assign bus.err_credit_ovf = r_err_ovf;

    // ------------------------------------------------------------------------
    // B FIFO
    // ------------------------------------------------------------------------
    // Entry storage is not reset; the head is don't-care while level is 0.
    always_ff @(posedge clk_wr) begin
        if (w_b_push) begin
            r_b_mem[r_b_wptr[c_b_aw-1:0]] <= {bus.m_axi_bid, bus.m_axi_bresp};
        end
    end

    // Pointers and occupancy; reset drops any buffered responses.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_b_wptr  <= '0;
            r_b_rptr  <= '0;
            r_b_level <= '0;
        end else begin
            if (w_b_push) begin
                r_b_wptr <= r_b_wptr + 1'b1;
            end
            if (w_b_pop) begin
                r_b_rptr <= r_b_rptr + 1'b1;
            end
            case ({w_b_push, w_b_pop})
                2'b10:   r_b_level <= r_b_level + 1'b1;
                2'b01:   r_b_level <= r_b_level - 1'b1;
                default: r_b_level <= r_b_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // R FIFO
    // ------------------------------------------------------------------------
    // Beat storage: {rid, rdata, rresp, rlast}, written on AXI acceptance.
    always_ff @(posedge clk_wr) begin
        if (w_r_push) begin
            r_r_mem[r_r_wptr[c_r_aw-1:0]] <= {bus.m_axi_rid, bus.m_axi_rdata,
                                              bus.m_axi_rresp, bus.m_axi_rlast};
        end
    end

    // Pointers and occupancy; reset drops any buffered beats.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_r_wptr  <= '0;
            r_r_rptr  <= '0;
            r_r_level <= '0;
        end else begin
            if (w_r_push) begin
                r_r_wptr <= r_r_wptr + 1'b1;
            end
            if (w_r_pop) begin
                r_r_rptr <= r_r_rptr + 1'b1;
            end
            case ({w_r_push, w_r_pop})
                2'b10:   r_r_level <= r_r_level + 1'b1;
                2'b01:   r_r_level <= r_r_level - 1'b1;
                default: r_r_level <= r_r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Credit counters
    // ------------------------------------------------------------------------
    generate
        if (CREDIT_EN != 0) begin : g_credit
            // B credits: pop spends one, a return adds one, both cancel out;
            // a return at the ceiling is dropped (flagged separately).
            always_ff @(posedge clk_wr) begin
                if (rst_wr) begin
                    r_b_cnt <= bus.init_b_credit;
                end else if (bus.b_credit_ret && !w_b_pop) begin
                    if (r_b_cnt != c_cnt_max) begin
                        r_b_cnt <= r_b_cnt + 1'b1;
                    end
                end else if (w_b_pop && !bus.b_credit_ret) begin
                    r_b_cnt <= r_b_cnt - 1'b1;
                end
            end

            // R credits: same accounting, one credit per beat.
            always_ff @(posedge clk_wr) begin
                if (rst_wr) begin
                    r_r_cnt <= bus.init_r_credit;
                end else if (bus.r_credit_ret && !w_r_pop) begin
                    if (r_r_cnt != c_cnt_max) begin
                        r_r_cnt <= r_r_cnt + 1'b1;
                    end
                end else if (w_r_pop && !bus.r_credit_ret) begin
                    r_r_cnt <= r_r_cnt - 1'b1;
                end
            end
        end else begin : g_no_credit
            // Returns carry no meaning when forwarding is not credit-gated.
            logic w_unused_credit_ret;
            assign w_unused_credit_ret = bus.b_credit_ret ^ bus.r_credit_ret;

            // Counters just mirror the reset load and then hold.
            always_ff @(posedge clk_wr) begin
                if (rst_wr) begin
                    r_b_cnt <= bus.init_b_credit;
                    r_r_cnt <= bus.init_r_credit;
                end
            end
        end
    endgenerate

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_err_ovf <= 1'b0;
        end else if (w_b_ovf || w_r_ovf) begin
            r_err_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aib_axi_follower_resp_credit_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_aib_axi_follower_resp_credit_buf
// Description : Scoreboard bench. Two buffers (credit-gated and ungated) see
//               the same stimulus; a queue-based reference model per buffer
//               predicts occupancy, credits, handshakes and forwarded data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aib_axi_follower_resp_credit_buf;

    localparam int DW  = 128;
    localparam int IW  = 4;
    localparam int BD  = 8;
    localparam int RD  = 16;
    localparam int CW  = 8;
    localparam int BTW = IW + 2;
    localparam int RTW = IW + DW + 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus
    logic [IW-1:0] bid = '0;
    logic [1:0]    bresp = '0;
    logic          bvalid = 1'b0;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          b_tx_ready = 1'b0;
    logic          r_tx_ready = 1'b0;
    logic          b_ret = 1'b0;
    logic          r_ret = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    aib_axi_follower_resp_credit_buf_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_DEPTH(BD),
        .R_DEPTH(RD), .CREDIT_W(CW)) bus0 ();
    aib_axi_follower_resp_credit_buf_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_DEPTH(BD),
        .R_DEPTH(RD), .CREDIT_W(CW)) bus1 ();

    aib_axi_follower_resp_credit_buf #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_DEPTH(BD),
        .R_DEPTH(RD), .CREDIT_W(CW), .CREDIT_EN(1)) dut0 (
        .clk_wr (clk),
        .rst_wr (rst),
        .bus    (bus0)
    );

    aib_axi_follower_resp_credit_buf #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_DEPTH(BD),
        .R_DEPTH(RD), .CREDIT_W(CW), .CREDIT_EN(0)) dut1 (
        .clk_wr (clk),
        .rst_wr (rst),
        .bus    (bus1)
    );

    // Credit-gated buffer starts with 3/5 credits, ungated one with none
    localparam int INIT_B [2] = '{3, 0};
    localparam int INIT_R [2] = '{5, 0};

    assign bus0.init_b_credit = CW'(INIT_B[0]);
    assign bus0.init_r_credit = CW'(INIT_R[0]);
    assign bus1.init_b_credit = CW'(INIT_B[1]);
    assign bus1.init_r_credit = CW'(INIT_R[1]);

    assign bus0.m_axi_bid = bid;      assign bus1.m_axi_bid = bid;
    assign bus0.m_axi_bresp = bresp;  assign bus1.m_axi_bresp = bresp;
    assign bus0.m_axi_bvalid = bvalid; assign bus1.m_axi_bvalid = bvalid;
    assign bus0.m_axi_rid = rid;      assign bus1.m_axi_rid = rid;
    assign bus0.m_axi_rdata = rdata;  assign bus1.m_axi_rdata = rdata;
    assign bus0.m_axi_rresp = rresp;  assign bus1.m_axi_rresp = rresp;
    assign bus0.m_axi_rlast = rlast;  assign bus1.m_axi_rlast = rlast;
    assign bus0.m_axi_rvalid = rvalid; assign bus1.m_axi_rvalid = rvalid;
    assign bus0.b_tx_ready = b_tx_ready; assign bus1.b_tx_ready = b_tx_ready;
    assign bus0.r_tx_ready = r_tx_ready; assign bus1.r_tx_ready = r_tx_ready;
    assign bus0.b_credit_ret = b_ret; assign bus1.b_credit_ret = b_ret;
    assign bus0.r_credit_ret = r_ret; assign bus1.r_credit_ret = r_ret;

    // DUT outputs gathered per instance
    logic [BTW-1:0] bdat [2];
    logic [RTW-1:0] rdat [2];
    logic           bval [2], rval [2], brdy [2], rrdy [2], oerr [2];
    logic [CW-1:0]  bcnt [2], rcnt [2];
    logic [3:0]     blev [2];
    logic [4:0]     rlev [2];

    assign bdat[0] = bus0.b_tx_data;      assign bdat[1] = bus1.b_tx_data;
    assign rdat[0] = bus0.r_tx_data;      assign rdat[1] = bus1.r_tx_data;
    assign bval[0] = bus0.b_tx_valid;     assign bval[1] = bus1.b_tx_valid;
    assign rval[0] = bus0.r_tx_valid;     assign rval[1] = bus1.r_tx_valid;
    assign brdy[0] = bus0.m_axi_bready;   assign brdy[1] = bus1.m_axi_bready;
    assign rrdy[0] = bus0.m_axi_rready;   assign rrdy[1] = bus1.m_axi_rready;
    assign oerr[0] = bus0.err_credit_ovf; assign oerr[1] = bus1.err_credit_ovf;
    assign bcnt[0] = bus0.b_credit_cnt;   assign bcnt[1] = bus1.b_credit_cnt;
    assign rcnt[0] = bus0.r_credit_cnt;   assign rcnt[1] = bus1.r_credit_cnt;
    assign blev[0] = bus0.b_level;        assign blev[1] = bus1.b_level;
    assign rlev[0] = bus0.r_level;        assign rlev[1] = bus1.r_level;

    // ------------------------------------------------------------------------
    // Reference model: expected FIFO contents as queues, credits as integers
    // ------------------------------------------------------------------------
    logic [BTW-1:0] bq [2][$];
    logic [RTW-1:0] rq [2][$];
    int             bcr [2] = '{3, 0};
    int             rcr [2] = '{5, 0};
    bit             merr [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: inputs are stable between posedge+1 and the next posedge, so
    // everything is observed on the falling edge and the model is advanced
    // to the state after the coming rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ce, ev_b, ev_r, er_b, er_r;
            int nb, nr;
            ce   = (k == 0);
            ev_b = !rst && (bq[k].size() != 0) && (!ce || bcr[k] != 0);
            ev_r = !rst && (rq[k].size() != 0) && (!ce || rcr[k] != 0);
            er_b = !rst && (bq[k].size() != BD);
            er_r = !rst && (rq[k].size() != RD);

            chk("b_level", k, 32'(blev[k]), bq[k].size());
            chk("r_level", k, 32'(rlev[k]), rq[k].size());
            chk("b_credit_cnt", k, 32'(bcnt[k]), bcr[k]);
            chk("r_credit_cnt", k, 32'(rcnt[k]), rcr[k]);
            chk("b_tx_valid", k, 32'(bval[k]), 32'(ev_b));
            chk("r_tx_valid", k, 32'(rval[k]), 32'(ev_r));
            chk("m_axi_bready", k, 32'(brdy[k]), 32'(er_b));
            chk("m_axi_rready", k, 32'(rrdy[k]), 32'(er_r));
            chk("err_credit_ovf", k, 32'(oerr[k]), 32'(merr[k]));

            // Forwarded entries must come out in acceptance order
            if (ev_b && b_tx_ready) begin
                vectors++;
                if (bdat[k] !== bq[k][0]) begin
                    miscompares++;
                    $display("FAIL b_tx_data dut%0d t=%0t: got %h expected %h",
                             k, $time, bdat[k], bq[k][0]);
                end
                void'(bq[k].pop_front());
            end
            if (ev_r && r_tx_ready) begin
                vectors++;
                if (rdat[k] !== rq[k][0]) begin
                    miscompares++;
                    $display("FAIL r_tx_data dut%0d t=%0t: got %h expected %h",
                             k, $time, rdat[k], rq[k][0]);
                end
                void'(rq[k].pop_front());
            end
            if (bvalid && er_b) bq[k].push_back({bid, bresp});
            if (rvalid && er_r) rq[k].push_back({rid, rdata, rresp, rlast});

            // Credit balance: returns add, pops spend, ceiling saturates
            if (ce) begin
                nb = bcr[k] + int'(b_ret) - int'(ev_b && b_tx_ready);
                nr = rcr[k] + int'(r_ret) - int'(ev_r && r_tx_ready);
                if (nb > CMAX) begin nb = CMAX; merr[k] = 1'b1; end
                if (nr > CMAX) begin nr = CMAX; merr[k] = 1'b1; end
                bcr[k] = nb;
                rcr[k] = nr;
            end

            if (rst) begin
                bq[k].delete();
                rq[k].delete();
                bcr[k]  = INIT_B[k];
                rcr[k]  = INIT_R[k];
                merr[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        bid   = IW'($urandom);
        bresp = 2'($urandom);
        rid   = IW'($urandom);
        rdata = {$urandom, $urandom, $urandom, $urandom};
        rresp = 2'($urandom);
        rlast = 1'($urandom);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            rand_beat();
            bvalid     = ($urandom_range(0, 99) < 50);
            rvalid     = ($urandom_range(0, 99) < 60);
            b_tx_ready = ($urandom_range(0, 99) < 70);
            r_tx_ready = ($urandom_range(0, 99) < 70);
            b_ret      = ($urandom_range(0, 99) < 35);
            r_ret      = ($urandom_range(0, 99) < 45);
            cyc(1);
        end
        bvalid = 1'b0; rvalid = 1'b0; b_ret = 1'b0; r_ret = 1'b0;
    endtask

    task automatic drain();
        bvalid = 1'b0; rvalid = 1'b0;
        b_tx_ready = 1'b1; r_tx_ready = 1'b1;
        b_ret = 1'b1; r_ret = 1'b1;
        cyc(40);
        b_ret = 1'b0; r_ret = 1'b0;
    endtask

    initial begin
        // Reset held for several cycles, then released
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Five write responses against three credits, then one return
        b_tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bid = IW'(i); bresp = 2'($urandom); bvalid = 1'b1;
            cyc(1);
        end
        bvalid = 1'b0;
        cyc(4);
        b_ret = 1'b1; cyc(1); b_ret = 1'b0;
        cyc(3);

        // Fill R to capacity with the link stalled, then open the link while
        // still pushing; spend down to 2 credits, then pop+return together
        r_tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            rand_beat(); rvalid = 1'b1;
            cyc(1);
        end
        r_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_beat(); cyc(1);
        end
        r_ret = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_beat(); cyc(1);
        end
        rvalid = 1'b0;
        cyc(20);
        r_ret = 1'b0;

        // Drive B credits past the counter ceiling
        b_ret = 1'b1;
        cyc(CMAX + 6);
        b_ret = 1'b0;
        cyc(2);

        // Eight-beat burst with rlast on the final beat, returns pulsing
        r_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_beat(); rid = 4'h5; rlast = (i == 7); rvalid = 1'b1;
            r_ret = i[0]; b_ret = ~i[0];
            cyc(1);
        end
        rvalid = 1'b0; r_ret = 1'b0; b_ret = 1'b0;
        cyc(12);

        // Mixed random traffic
        rand_phase(1500);
        drain();

        // Buffer 4 B and 6 R entries with the link stalled, then reset
        b_tx_ready = 1'b0; r_tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_beat(); bvalid = (i < 4); rvalid = 1'b1;
            cyc(1);
        end
        bvalid = 1'b0; rvalid = 1'b0;
        rst = 1'b1; cyc(1); rst = 1'b0;
        b_tx_ready = 1'b1; r_tx_ready = 1'b1;
        cyc(5);

        rand_phase(300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
